// File: rtl/tff_count_sequencer_if.sv
// Control/status bundle between system control logic and the T-flip-flop counter sequencer.
// The master drives the controls; the slave (the sequencer) returns the toggle mask and status.
interface tff_count_sequencer_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  auto_reload;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      t;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  done;
  logic [1:0]            state;

  modport master (
    output start, stop, clear, auto_reload, limit, prescale,
    input  t, q, busy, done, state
  );

  modport slave (
    input  start, stop, clear, auto_reload, limit, prescale,
    output t, q, busy, done, state
  );
endinterface

// File: rtl/tff_count_sequencer.sv
// Sequencer for a WIDTH-bit T-flip-flop counter: emits the toggle mask t (next = q ^ t),
// mirrors the count in q, and handles run/pause/clear, prescaling and terminal count.
module tff_count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  tff_count_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH-1:0]      w_q_next;
  logic [WIDTH-1:0]      w_q_inc;
  logic [WIDTH-1:0]      w_t;
  logic [PRESCALE_W-1:0] r_presc;
  logic [PRESCALE_W-1:0] w_presc_next;
  logic                  w_step;
  logic                  w_term;
  logic                  w_go;

  assign w_q_inc = r_q + WIDTH'(1);
  assign w_step  = (r_state == RUN) && (r_presc == bus.prescale) && !bus.clear;
  assign w_term  = w_step && (r_q == bus.limit);
  // A simultaneous stop cancels a start everywhere.
  assign w_go    = bus.start && !bus.stop;

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_presc_next = r_presc;
    w_t          = '0;

    if (bus.clear) begin
      // Toggling every set bit drives the external chain to zero alongside q.
      w_t          = r_q;
      w_q_next     = '0;
      w_presc_next = '0;
      w_state_next = IDLE;
    end else begin
      case (r_state)
        RUN: begin
          if (w_step) begin
            w_presc_next = '0;
            if (w_term) begin
              w_t      = r_q;
              w_q_next = '0;
              if (!bus.auto_reload) begin
                w_state_next = DONE;
              end
            end else begin
              w_t      = r_q ^ w_q_inc;
              w_q_next = w_q_inc;
            end
          end else begin
            w_presc_next = r_presc + PRESCALE_W'(1);
          end
          // A one-shot terminal step already chose DONE, which outranks PAUSE.
          if (bus.stop && (w_state_next == RUN)) begin
            w_state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (w_go) begin
            w_state_next = RUN;
          end
        end
        default: begin
          w_presc_next = '0;
          if (w_go) begin
            w_state_next = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_presc <= w_presc_next;
    end
  end

  assign bus.t     = w_t;
  assign bus.q     = r_q;
  assign bus.busy  = (r_state == RUN);
  assign bus.done  = w_term;
  assign bus.state = r_state;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer: directed scenarios followed by random control traffic,
// all compared cycle by cycle against a count-level reference model and an external T-flip-flop chain.
module tb_tff_count_sequencer;

  localparam int W  = 4;
  localparam int PW = 8;

  logic clk;
  logic reset;

  tff_count_sequencer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  tff_count_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count value, phase within the prescale period, and mode (0 idle, 1 run, 2 pause, 3 done).
  int m_q, m_p, m_mode;
  logic [W-1:0] chain;
  logic [W-1:0] last_t;
  logic         last_done;
  logic         last_step;
  int           done_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_p = 0; m_mode = 0; chain = '0;
  endtask

  // One clock: drive controls after the falling edge, compare combinational outputs and the
  // registered state, then advance the model and the external chain on the rising edge.
  task automatic cycle(input bit s, input bit sp, input bit c);
    int nq, np, nmode;
    bit step, term;
    @(negedge clk);
    bus.start = s; bus.stop = sp; bus.clear = c;
    #1;
    step = (m_mode == 1) && (m_p == int'(bus.prescale)) && !c;
    term = step && (m_q == int'(bus.limit));
    if (c)         nq = 0;
    else if (term) nq = 0;
    else if (step) nq = (m_q + 1) % (1 << W);
    else           nq = m_q;

    check("q",     32'(bus.q),     32'(m_q));
    check("state", 32'(bus.state), 32'(m_mode));
    check("busy",  32'(bus.busy),  32'(m_mode == 1));
    check("done",  32'(bus.done),  32'(term));
    check("t",     32'(bus.t),     32'(m_q ^ nq));

    np = m_p; nmode = m_mode;
    if (c) begin
      np = 0; nmode = 0;
    end else if (m_mode == 1) begin
      np = step ? 0 : (m_p + 1) % (1 << PW);
      if (term && !bus.auto_reload) nmode = 3;
      else if (sp)                  nmode = 2;
    end else begin
      if (m_mode != 2) np = 0;
      if (s && !sp) nmode = 1;
    end

    last_t = bus.t; last_done = bus.done; last_step = step;
    if (term) done_count++;
    @(posedge clk);
    chain = chain ^ last_t;
    m_q = nq; m_p = np; m_mode = nmode;
    #1;
    check("chain", 32'(chain), 32'(bus.q));
  endtask

  initial begin
    logic [W-1:0] held_q;
    int guard;

    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.auto_reload = 0;
    bus.limit = 4'd9; bus.prescale = 8'd0;
    reset = 1'b0;
    model_reset();
    #12;
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: run to 5, then an asynchronous reset mid-cycle.
    cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    check("pre_reset_q", 32'(bus.q), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("async_q",     32'(bus.q),     32'd0);
    check("async_t",     32'(bus.t),     32'd0);
    check("async_state", 32'(bus.state), 32'd0);
    check("async_busy",  32'(bus.busy),  32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // 2: one-shot to limit 9.
    bus.limit = 4'd9; bus.prescale = 8'd0; bus.auto_reload = 0;
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("t_3to4", 32'(last_t), 32'b0111);
    repeat (5) cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("t_9to0", 32'(last_t), 32'b1001);
    check("done_9to0", 32'(last_done), 32'd1);
    cycle(0, 0, 0);
    check("oneshot_state", 32'(bus.state), 32'b11);
    check("oneshot_q", 32'(bus.q), 32'd0);

    // 3: auto-reload at 15, three full periods.
    bus.limit = 4'd15; bus.auto_reload = 1;
    cycle(1, 0, 0);
    done_count = 0;
    repeat (48) cycle(0, 0, 0);
    check("reload_pulses", 32'(done_count), 32'd3);
    check("t_15to0", 32'(last_t), 32'b1111);
    check("reload_state", 32'(bus.state), 32'b01);

    // 4: prescale 3, pause one clock after a step, resume.
    bus.prescale = 8'd3;
    guard = 0;
    do begin
      cycle(0, 0, 0);
      guard++;
    end while (!last_step && guard < 8);
    check("presc_step_seen", 32'(last_step), 32'd1);
    cycle(0, 1, 0);
    held_q = bus.q;
    repeat (10) cycle(0, 0, 0);
    check("pause_hold_q", 32'(bus.q), 32'(held_q));
    check("pause_state", 32'(bus.state), 32'b10);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("resume_nostep", 32'(bus.q), 32'(held_q));
    cycle(0, 0, 0);
    check("resume_step", 32'(last_step), 32'd1);

    // 5: clear with start and stop at q=5.
    bus.prescale = 8'd0;
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    cycle(1, 1, 1);
    check("clear_t", 32'(last_t), 32'b0101);
    check("clear_done", 32'(last_done), 32'd0);
    check("clear_state", 32'(bus.state), 32'd0);

    // 6: limit 0, prescale 1; start+stop interactions.
    bus.limit = 4'd0; bus.prescale = 8'd1;
    cycle(1, 0, 0);
    done_count = 0;
    repeat (6) cycle(0, 0, 0);
    check("lim0_pulses", 32'(done_count), 32'd3);
    check("lim0_q", 32'(bus.q), 32'd0);
    cycle(1, 1, 0);
    check("startstop_run", 32'(bus.state), 32'b10);
    cycle(1, 1, 0);
    check("startstop_pause", 32'(bus.state), 32'b10);

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus.limit = W'($urandom);
      if ($urandom_range(0, 19) == 0) bus.prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  bus.auto_reload = 1'($urandom);
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
